pwm_ramp_sequencer: RTL
=======================

// Module: pwm_ramp_sequencer
// PURPOSE
//   Soft-start / fade controller that sits in front of the PWM generator in pwm_top.
//   Accepts a target duty over a valid/ready handshake and steps the live duty toward
//   it by STEP every PRESCALE PWM periods, aligned to period boundaries.
//   Prevents abrupt duty jumps on motor/LED loads; the ui_in/uio_in decode feeds it.
// PARAMETERS
//   DUTY_W    8   width of duty, target and step values
//   PRESC_W   8   width of the period prescaler
// PORTS
//   clk         in   1        single clock
//   rst         in   1        asynchronous, active-high reset
//   ena         in   1        block enable; low freezes all state
//   period_end  in   1        1-cycle pulse from PWM counter at end of each period
//   tgt_valid   in   1        new target duty offered
//   tgt_ready   out  1        target accepted when tgt_valid && tgt_ready
//   tgt_duty    in   DUTY_W   requested final duty
//   step        in   DUTY_W   duty increment per tick (0 treated as 1)
//   prescale    in   PRESC_W  periods per tick minus 1 (0 = step every period)
//   duty_out    out  DUTY_W   duty value presented to the PWM shadow register
//   duty_load   out  1        1-cycle strobe when duty_out changes
//   busy        out  1        high while ramping (state RAMP)
//   done        out  1        1-cycle pulse when duty_out reaches target
// BEHAVIOUR
//   Reset (async, rst=1): duty_out=0, target=0, tick count=0, state IDLE,
//     tgt_ready=0, duty_load=0, busy=0, done=0. Reset mid-ramp aborts immediately.
//   tgt_ready = ena && !rst (combinational); retargeting mid-ramp is allowed.
//   Accept: target register <= tgt_duty on the clock edge of the handshake.
//     If tgt_duty != duty_out -> state RAMP next cycle; else stay IDLE, pulse done.
//   Tick: prescaler counts period_end pulses; tick asserted on the period_end where
//     count == prescale, count then wraps to 0. Counter free-runs in all states
//     (cadence not reset by retarget). prescale change takes effect at next wrap.
//   States: IDLE (hold duty) -> RAMP (on accepted target != duty_out).
//     RAMP on tick: d = |target - duty_out|; s = max(step,1).
//       d <= s : duty_out <= target, duty_load=1, done=1, -> IDLE.
//       else   : duty_out <= duty_out +/- s toward target, duty_load=1, stay RAMP.
//   Latency: duty_out/duty_load update 1 cycle after the tick's period_end edge;
//     PWM latches at its next period boundary.
//   Arithmetic: never wraps; clamping to target guarantees 0..2^DUTY_W-1.
//   Simultaneous accept + tick: tick uses old target and old duty_out; new target
//     latched same edge and governs subsequent ticks (RAMP/IDLE re-evaluated then).
//   ena=0: no accepts, no ticks, counter and duty_out held, strobes forced 0.
//   period_end while ena=0 is ignored (not counted).
// CONFIGURATION
//   PWM_RAMP_IRQ_EN defined: adds ports irq (out,1) and irq_clr (in,1); irq is a
//     sticky flag set by done, cleared by irq_clr (clear wins over set same cycle),
//     reset to 0.
//   Not defined: ports absent; done pulse is the only completion indication.
// STRUCTURE
//   pwm_pkg: state enum {IDLE, RAMP}, default DUTY_W/PRESC_W localparams,
//     function abs_diff(a,b) returning DUTY_W-bit magnitude.
//   Sub-module pwm_tick_div: period_end prescaler (ena, prescale -> tick).
//   Top: target register, RAMP FSM, duty register, strobe/IRQ logic.
// TESTING
//   T1 reset: assert rst mid-ramp at duty 0x40 -> all outputs 0 asynchronously,
//     IDLE after release, no duty_load.
//   T2 up-ramp: prescale=0, step=0x10, tgt 0x00->0x35 -> duty_out 0x10,0x20,0x30,0x35
//     on 4 consecutive period_end; done pulse with last duty_load; busy low after.
//   T3 down-ramp w/ prescale: duty 0x80, prescale=2, step=0x20, tgt 0x30 -> updates
//     every 3rd period_end: 0x60,0x40,0x30; exactly 3 duty_load strobes.
//   T4 retarget + simultaneous tick: ramping 0x00->0xFF step 0x40, accept 0x50 on
//     same cycle as tick at duty 0x40 -> duty 0x80, then 0x50 next tick, done.
//   T5 edge values: step=0 -> increments of 1; tgt == duty_out -> done pulse,
//     no duty_load; tgt 0xFF step 0xF0 from 0x20 -> 0xFF, no overflow.
//   T6 ena/IRQ: ena=0 for 5 period_end -> duty frozen, tgt_ready=0; with
//     PWM_RAMP_IRQ_EN, irq sets on done, holds, clears on irq_clr (clear wins).

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM ramp sequencer slice.
// Optional feature macro used by this slice: PWM_RAMP_IRQ_EN (see pwm_ramp_sequencer).
package pwm_pkg;

  localparam int DEF_DUTY_W  = 8;
  localparam int DEF_PRESC_W = 8;

  // IDLE holds the live duty; RAMP steps it toward the latched target on each tick.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_t;

  // Magnitude of the distance between two duty values, without wrap-around.
  function automatic logic [DEF_DUTY_W-1:0] abs_diff(input logic [DEF_DUTY_W-1:0] a,
                                                     input logic [DEF_DUTY_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/pwm_tick_div.sv
// Period prescaler: counts period_end pulses and raises tick on the pulse where
// the count reaches the latched prescale value. The counter free-runs regardless
// of what the ramp FSM is doing; a new prescale value is picked up only on wrap,
// so a change never truncates or stretches the interval already in progress.
module pwm_tick_div
  import pwm_pkg::*;
#(
  parameter int PRESC_W = DEF_PRESC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               period_end,
  input  logic [PRESC_W-1:0] prescale,
  output logic               tick
);

  logic [PRESC_W-1:0] count_reg;
  logic [PRESC_W-1:0] limit_reg;
  logic               wrap;

  // Disabled period_end pulses are ignored entirely.
  assign wrap = ena && period_end && (count_reg == limit_reg);
  assign tick = wrap;

  // Period counter with wrap-time reload of the prescale limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
      limit_reg <= '0;
    end else if (ena && period_end) begin
      if (wrap) begin
        count_reg <= '0;
        limit_reg <= prescale;
      end else begin
        count_reg <= count_reg + PRESC_W'(1);
      end
    end
  end

endmodule

// File: rtl/pwm_ramp_sequencer.sv
// Soft-start / fade controller in front of the PWM generator. Accepts a target
// duty over valid/ready and walks duty_out toward it by max(step,1) on every
// prescaled period tick, clamping the last step so the value never wraps.
// Optional feature: define PWM_RAMP_IRQ_EN to add a sticky completion flag
// (irq) with a clear input (irq_clr); clear has priority over a same-cycle set.
module pwm_ramp_sequencer
  import pwm_pkg::*;
#(
  parameter int DUTY_W  = DEF_DUTY_W,
  parameter int PRESC_W = DEF_PRESC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               period_end,
  input  logic               tgt_valid,
  output logic               tgt_ready,
  input  logic [DUTY_W-1:0]  tgt_duty,
  input  logic [DUTY_W-1:0]  step,
  input  logic [PRESC_W-1:0] prescale,
  output logic [DUTY_W-1:0]  duty_out,
  output logic               duty_load,
  output logic               busy,
`ifdef PWM_RAMP_IRQ_EN
  input  logic               irq_clr,
  output logic               irq,
`endif
  output logic               done
);

  state_t            state_reg, state_next;
  logic [DUTY_W-1:0] target_reg, target_next;
  logic [DUTY_W-1:0] duty_reg, duty_next;
  logic              load_reg, load_next;
  logic              done_reg, done_next;
  logic [DUTY_W-1:0] step_eff;
  logic [DUTY_W-1:0] diff;
  logic              going_up;
  logic              accept;
  logic              tick;

  // Ready is purely a function of enable; retargeting mid-ramp is allowed.
  assign tgt_ready = ena && !rst;
  assign accept    = ena && tgt_valid;

  // A zero step would stall the ramp forever, so it behaves as a step of one.
  assign step_eff = (step == '0) ? DUTY_W'(1) : step;
  assign going_up = (target_reg > duty_reg);
  assign diff     = going_up ? (target_reg - duty_reg) : (duty_reg - target_reg);

  pwm_tick_div #(
    .PRESC_W    (PRESC_W)
  ) u_tick_div (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .period_end (period_end),
    .prescale   (prescale),
    .tick       (tick)
  );

  // Next-state: the tick step is computed from the old target and duty first,
  // then a same-cycle accept overrides the target and re-decides RAMP/IDLE
  // against the duty value that this edge will produce.
  always_comb begin
    state_next  = state_reg;
    target_next = target_reg;
    duty_next   = duty_reg;
    load_next   = 1'b0;
    done_next   = 1'b0;
    if (ena) begin
      if ((state_reg == RAMP) && tick) begin
        load_next = 1'b1;
        if (diff <= step_eff) begin
          duty_next  = target_reg;
          done_next  = 1'b1;
          state_next = IDLE;
        end else if (going_up) begin
          duty_next = duty_reg + step_eff;
        end else begin
          duty_next = duty_reg - step_eff;
        end
      end
      if (accept) begin
        target_next = tgt_duty;
        if (tgt_duty != duty_next) begin
          state_next = RAMP;
        end else begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
    end
  end

  // State, target, duty and strobe registers; reset aborts any ramp at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      target_reg <= '0;
      duty_reg   <= '0;
      load_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      target_reg <= target_next;
      duty_reg   <= duty_next;
      load_reg   <= load_next;
      done_reg   <= done_next;
    end
  end

  assign duty_out  = duty_reg;
  assign duty_load = load_reg;
  assign done      = done_reg;
  assign busy      = (state_reg == RAMP);

`ifdef PWM_RAMP_IRQ_EN
  logic irq_reg;

  // Sticky completion flag: set by the done pulse, clear takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_reg <= 1'b0;
    end else if (irq_clr) begin
      irq_reg <= 1'b0;
    end else if (done_reg) begin
      irq_reg <= 1'b1;
    end
  end

  assign irq = irq_reg;
`endif

endmodule
